shift_regg_param: RTL and testbench
===================================

SHIFT_REGG_PARAM -- requirements
Module: shift_regg_param

Interface
REQ-001 Parameter WIDTH, default 8, shift register length in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 si  input  1  serial data in.
REQ-005 shift_en  input  1  shift enable; low stalls the shift without losing state.
REQ-006 dir  input  1  shift direction; 0 = MSB-first (si enters bit 0, so from bit WIDTH-1), 1 = LSB-first (si enters bit WIDTH-1, so from bit 0).
REQ-007 load_valid  input  1  parallel load request.
REQ-008 load_data  input  WIDTH  parallel word to be shifted out.
REQ-009 load_ready  output  1  block can accept a load.
REQ-010 so  output  1  serial data out.
REQ-011 po  output  WIDTH  parallel view of the shift register.
REQ-012 po_valid  output  1  one-cycle pulse; po holds a complete captured word.
REQ-013 busy  output  1  word transfer in progress.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE: load_ready=1, busy=0, po_valid=0.
REQ-016 In IDLE, when load_valid=1 on an edge, the block SHALL load load_data into the register, latch dir, clear the bit counter, and enter SHIFT.
REQ-017 In SHIFT: load_ready=0, busy=1; load_valid is ignored.
REQ-018 In SHIFT, on an edge with shift_en=1, the block SHALL shift one position in the latched direction, insert si, and increment the counter.
REQ-019 In SHIFT, on an edge with shift_en=0, the register and counter SHALL hold.
REQ-020 A change on dir during SHIFT SHALL have no effect until the next load.
REQ-021 On the shift edge where counter = WIDTH-1, the block SHALL enter DONE; exactly WIDTH shifts occur per word.
REQ-022 In DONE: po_valid=1 for exactly one cycle, busy=1, load_ready=0; po holds the WIDTH bits captured from si. The next state SHALL be IDLE unconditionally.
REQ-023 so SHALL be combinational from the register: bit WIDTH-1 when the latched dir=0, bit 0 when latched dir=1.
REQ-024 po SHALL always equal the register contents.
REQ-025 Counter width SHALL be $clog2(WIDTH); the counter SHALL never wrap within a word.
REQ-026 Latency: with shift_en held high, po_valid SHALL assert WIDTH+1 cycles after the load-accept edge, and load_ready SHALL reassert one cycle after that.
REQ-027 A load_valid held across DONE SHALL be accepted only in the following IDLE cycle, never in DONE.

Reset
REQ-028 While rst_n=0 at an edge, the block SHALL set: state IDLE, register 0, counter 0, latched dir 0, po_valid 0. This gives so=0, po=0, load_ready=1 and busy=0 on the next cycle.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the word with no po_valid pulse; reset SHALL dominate load_valid.

Structure
REQ-030 Shared package shift_regg_pkg SHALL hold:
- state enum (IDLE, SHIFT, DONE)
- direction constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1
REQ-031 The bit counter and its terminal-count compare SHALL be a sub-module shift_cnt parametrised by WIDTH; all other logic SHALL be inline.

Verification
REQ-032 WIDTH=8, load 0xA5, dir=0, shift_en=1, si=0x3C MSB-first -> so = 1,0,1,0,0,1,0,1; po_valid pulses once with po=0x3C, 9 cycles after load accept.
REQ-033 WIDTH=8, load 0xA5, dir=1, si=0x3C LSB-first -> so = 1,0,1,0,0,1,0,1 (LSB first); po=0x3C at po_valid.
REQ-034 shift_en low for 3 cycles after the 4th shift -> register and so hold; po_valid delayed by exactly 3 cycles; the word is unchanged.
REQ-035 load_valid held high continuously with 0x01 then 0xFF -> load accepted only in IDLE; no acceptance in SHIFT or DONE; words back-to-back with a one-cycle IDLE gap.
REQ-036 rst_n low for 1 cycle after the 5th shift -> no po_valid; po=0, so=0, load_ready=1; the next load runs a full 8 shifts.
REQ-037 WIDTH=2 and WIDTH=64 builds, one word each with all-ones si -> po all ones and po_valid after WIDTH+1 cycles.

Source files
------------

// File: rtl/shift_regg_pkg.sv
// Shared types and constants for the parallel-load / serial-shift register block.
package shift_regg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_cnt.sv
// Bit counter for one word transfer; flags the shift that completes the word.
module shift_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_regg_param.sv
// Loads a word, shifts it out serially while capturing si, then pulses po_valid.
module shift_regg_param
    import shift_regg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             so,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic             dir_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_last;

    assign cnt_clr = (state == IDLE) && load_valid;
    assign cnt_inc = (state == SHIFT) && shift_en;

    shift_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    // Direction is latched at load so a toggling dir input cannot disturb a word in flight.
    assign so = (dir_q == DIR_LSB_FIRST) ? sreg[0] : sreg[WIDTH-1];
    assign po = sreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            dir_q      <= DIR_MSB_FIRST;
            po_valid   <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg       <= load_data;
                        dir_q      <= dir;
                        state      <= SHIFT;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (dir_q == DIR_LSB_FIRST) begin
                            sreg <= {si, sreg[WIDTH-1:1]};
                        end else begin
                            sreg <= {sreg[WIDTH-2:0], si};
                        end
                        if (cnt_last) begin
                            state    <= DONE;
                            po_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    po_valid   <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    po_valid   <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_regg_param.sv
// Directed bench for shift_regg_param: scoreboarded serial/parallel words at WIDTH 8, 2 and 64.
module tb_shift_regg_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       si, shift_en, dir, load_valid;
    logic [7:0] load_data;
    logic       load_ready, so, po_valid, busy;
    logic [7:0] po;

    logic        lv2, rdy2, so2, pv2, busy2;
    logic [1:0]  po2;
    logic        lv64, rdy64, so64, pv64, busy64;
    logic [63:0] po64;

    int tests = 0;
    int fails = 0;

    logic       so_q[$];
    logic [7:0] po_q[$];

    always #5 clk = ~clk;

    shift_regg_param #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .shift_en(shift_en), .dir(dir),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .so(so), .po(po), .po_valid(po_valid), .busy(busy)
    );

    shift_regg_param #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .si(1'b1), .shift_en(1'b1), .dir(1'b0),
        .load_valid(lv2), .load_data(2'b00), .load_ready(rdy2),
        .so(so2), .po(po2), .po_valid(pv2), .busy(busy2)
    );

    shift_regg_param #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .si(1'b1), .shift_en(1'b1), .dir(1'b1),
        .load_valid(lv64), .load_data(64'd0), .load_ready(rdy64),
        .so(so64), .po(po64), .po_valid(pv64), .busy(busy64)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Entered and left at a negedge in IDLE; stall_at = shifts completed before shift_en drops.
    task automatic run_word(input logic [7:0] data, input logic [7:0] siw, input logic d,
                            input int stall_at, input int stall_len, input bit hold);
        int         shifts;
        int         cyc;
        int         stalled;
        logic [7:0] po_hold;
        check("idle_ready", 64'(load_ready), 64'(1));
        load_valid = 1'b1;
        load_data  = data;
        dir        = d;
        shift_en   = 1'b1;
        for (int i = 0; i < 8; i++) so_q.push_back(d ? data[i] : data[7-i]);
        po_q.push_back(siw);
        @(posedge clk);
        @(negedge clk);
        load_valid = hold;
        if (hold) load_data = ~data;
        shifts  = 0;
        stalled = 0;
        cyc     = 1;
        po_hold = '0;
        while (shifts < 8) begin
            check("shift_busy", 64'(busy), 64'(1));
            check("shift_ready", 64'(load_ready), 64'(0));
            check("shift_pv", 64'(po_valid), 64'(0));
            dir = 1'($urandom);
            if (shifts == stall_at && stalled < stall_len) begin
                shift_en = 1'b0;
                if (stalled == 0) po_hold = po;
                else check("stall_po", 64'(po), 64'(po_hold));
                check("stall_so", 64'(so), 64'(so_q[0]));
                stalled++;
            end else begin
                if (stall_len > 0 && shifts == stall_at) check("stall_po", 64'(po), 64'(po_hold));
                shift_en = 1'b1;
                check("so", 64'(so), 64'(so_q.pop_front()));
                si = d ? siw[shifts] : siw[7-shifts];
                shifts++;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_pv", 64'(po_valid), 64'(1));
        check("latency", 64'(cyc), 64'(9 + stall_len));
        check("done_po", 64'(po), 64'(po_q.pop_front()));
        check("done_busy", 64'(busy), 64'(1));
        check("done_ready", 64'(load_ready), 64'(0));
        @(negedge clk);
        check("pv_pulse", 64'(po_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n = 1'b0; si = 1'b0; shift_en = 1'b0; dir = 1'b0;
        load_valid = 1'b0; load_data = '0; lv2 = 1'b0; lv64 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_po", 64'(po), 64'(0));
        check("rst_so", 64'(so), 64'(0));
        check("rst_ready", 64'(load_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pv", 64'(po_valid), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_word(8'hA5, 8'h3C, 1'b0, -1, 0, 1'b0);
        run_word(8'hA5, 8'h3C, 1'b1, -1, 0, 1'b0);
        run_word(8'hA5, 8'h96, 1'b0, 4, 3, 1'b0);
        run_word(8'h6B, 8'hD2, 1'b1, 2, 2, 1'b0);

        // load_valid held high across both words: acceptance only in IDLE.
        run_word(8'h01, 8'h5A, 1'b0, -1, 0, 1'b1);
        run_word(8'hFF, 8'h81, 1'b0, -1, 0, 1'b1);
        load_valid = 1'b0;

        // Reset after the 5th shift aborts the word.
        check("pre_rst_ready", 64'(load_ready), 64'(1));
        load_valid = 1'b1; load_data = 8'hA5; dir = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0; shift_en = 1'b1;
        repeat (5) begin
            si = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        load_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        load_valid = 1'b0;
        check("abort_po", 64'(po), 64'(0));
        check("abort_so", 64'(so), 64'(0));
        check("abort_ready", 64'(load_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        seen = 0;
        repeat (12) begin
            if (po_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_pv", 64'(seen), 64'(0));
        run_word(8'hC3, 8'h3C, 1'b0, -1, 0, 1'b0);

        // WIDTH=2 with all-ones si.
        lv2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv2 = 1'b0;
        cyc = 1;
        while (!pv2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("w2_latency", 64'(cyc), 64'(3));
        check("w2_po", 64'(po2), 64'(2'b11));

        // WIDTH=64 with all-ones si.
        lv64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv64 = 1'b0;
        cyc = 1;
        while (!pv64 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("w64_latency", 64'(cyc), 64'(65));
        check("w64_po", po64, {64{1'b1}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
